// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state codes, line levels and default payload width.
// Imported by both TX and RX; STOP2 is only reachable when TX_TWO_STOP_EN is defined.
package uart_pkg;

  localparam int unsigned DATA_WIDTH_DEFAULT = 8;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    STOP2  = 3'd5
  } tx_state_e;

endpackage

// File: rtl/uart_tx_serializer.sv
// UART TX shift register and bit counter, sequenced by the uart_tx_ctrl FSM.
// ser_done rises once all DATA_WIDTH bits have been shifted to ser_data.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  load,
  input  logic                  shift_en,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  ser_data,
  output logic                  ser_done
);

  localparam int unsigned CW = $clog2(DATA_WIDTH + 1);

  logic [DATA_WIDTH-1:0] shift_reg;
  logic [CW-1:0]         bit_cnt;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if (load) begin
      shift_reg <= load_data;
      bit_cnt   <= '0;
    end else if (shift_en) begin
      shift_reg <= {1'b0, shift_reg[DATA_WIDTH-1:1]};
      bit_cnt   <= bit_cnt + 1'b1;
    end
  end

  // Counter counts bits already handed to the registered line, so done == all sent.
  assign ser_data = shift_reg[0];
  assign ser_done = (bit_cnt == CW'(DATA_WIDTH));

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmitter: start, DATA_WIDTH bits LSB-first, optional parity, stop bit(s).
// Define TX_TWO_STOP_EN to emit two stop bits per frame.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  BUSY
);

  tx_state_e state;
  logic      par_en_q;
  logic      par_typ_q;
  logic      data_par_q;
  logic      load;
  logic      shift_en;
  logic      ser_data;
  logic      ser_done;

`ifdef TX_TWO_STOP_EN
  localparam tx_state_e LAST_STOP = STOP2;
`else
  localparam tx_state_e LAST_STOP = STOP;
`endif

  // TX_OUT is registered, so the serializer is pre-shifted on the START->DATA edge.
  always_comb begin
    load     = DATA_VALID && ((state == IDLE) || (state == LAST_STOP));
    shift_en = (state == START) || ((state == DATA) && !ser_done);
  end

  uart_tx_serializer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_serializer (
    .CLK      (CLK),
    .RST      (RST),
    .load     (load),
    .shift_en (shift_en),
    .load_data(P_DATA),
    .ser_data (ser_data),
    .ser_done (ser_done)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      TX_OUT     <= STOP_BIT;
      BUSY       <= 1'b0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      data_par_q <= 1'b0;
    end else begin
      if (load) begin
        par_en_q   <= PAR_EN;
        par_typ_q  <= PAR_TYP;
        data_par_q <= ^P_DATA;
      end
      case (state)
        IDLE: begin
          if (DATA_VALID) begin
            state  <= START;
            TX_OUT <= START_BIT;
            BUSY   <= 1'b1;
          end else begin
            TX_OUT <= STOP_BIT;
            BUSY   <= 1'b0;
          end
        end
        START: begin
          state  <= DATA;
          TX_OUT <= ser_data;
        end
        DATA: begin
          if (!ser_done) begin
            TX_OUT <= ser_data;
          end else if (par_en_q) begin
            state  <= PARITY;
            TX_OUT <= data_par_q ^ par_typ_q;
          end else begin
            state  <= STOP;
            TX_OUT <= STOP_BIT;
          end
        end
        PARITY: begin
          state  <= STOP;
          TX_OUT <= STOP_BIT;
        end
`ifdef TX_TWO_STOP_EN
        STOP: begin
          state  <= STOP2;
          TX_OUT <= STOP_BIT;
        end
        STOP2: begin
          if (DATA_VALID) begin
            state  <= START;
            TX_OUT <= START_BIT;
          end else begin
            state  <= IDLE;
            TX_OUT <= STOP_BIT;
            BUSY   <= 1'b0;
          end
        end
`else
        STOP: begin
          if (DATA_VALID) begin
            state  <= START;
            TX_OUT <= START_BIT;
          end else begin
            state  <= IDLE;
            TX_OUT <= STOP_BIT;
            BUSY   <= 1'b0;
          end
        end
`endif
        default: begin
          state  <= IDLE;
          TX_OUT <= STOP_BIT;
          BUSY   <= 1'b0;
        end
      endcase
    end
  end

endmodule
